// File: rtl/gpio_wirethrough_sync.sv
// GPIO pass-through: optionally registered output path, synchronised and edge-detected input path.
// Optional feature macro: GPIO_WT_DEBOUNCE_EN (per-bit debounce between synchroniser and s_tri_i).
module gpio_wirethrough_sync #(
   parameter int unsigned C_NUM_CH          = 1,
   parameter int unsigned C_TRI_WIDTH       = 32,
   parameter int unsigned C_SYNC_STAGES     = 2,
   parameter int unsigned C_OUT_REG         = 1,
   parameter int unsigned C_EDGE_MODE       = 0,
   parameter int unsigned C_DEBOUNCE_CYCLES = 16
) (
   input  logic                                aclk,
   input  logic                                areset,
   input  logic [C_NUM_CH*C_TRI_WIDTH-1:0]     s_tri_t,
   input  logic [C_NUM_CH*C_TRI_WIDTH-1:0]     s_tri_o,
   output logic [C_NUM_CH*C_TRI_WIDTH-1:0]     s_tri_i,
   output logic [C_NUM_CH*C_TRI_WIDTH-1:0]     m_tri_t,
   output logic [C_NUM_CH*C_TRI_WIDTH-1:0]     m_tri_o,
   input  logic [C_NUM_CH*C_TRI_WIDTH-1:0]     m_tri_i,
   input  logic [C_NUM_CH*C_TRI_WIDTH-1:0]     edge_mask,
   input  logic [C_NUM_CH*C_TRI_WIDTH-1:0]     edge_clr,
   output logic [C_NUM_CH*C_TRI_WIDTH-1:0]     edge_status,
   output logic [C_NUM_CH-1:0]                 irq
);

   localparam int unsigned W = C_NUM_CH * C_TRI_WIDTH;
`ifdef GPIO_WT_DEBOUNCE_EN
   // Warm-up also covers the debounce latency so a pin held high through reset never flags.
   localparam int unsigned WARM_MAX = C_SYNC_STAGES + C_DEBOUNCE_CYCLES + 1;
`else
   localparam int unsigned WARM_MAX = C_SYNC_STAGES + 1;
`endif
   localparam int unsigned WARM_W = $clog2(WARM_MAX + 1);

   if (C_SYNC_STAGES < 2 || C_DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("gpio_wirethrough_sync: C_SYNC_STAGES must be >= 2 and C_DEBOUNCE_CYCLES >= 1");
   end

   // ---------------- output path ----------------
   if (C_OUT_REG != 0) begin : g_oreg
      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            m_tri_t <= '1;
            m_tri_o <= '0;
         end else begin
            m_tri_t <= s_tri_t;
            m_tri_o <= s_tri_o;
         end
      end
   end else begin : g_ocomb
      assign m_tri_t = s_tri_t;
      assign m_tri_o = s_tri_o;
   end

   // ---------------- input synchroniser ----------------
   logic [W-1:0] sync_q [C_SYNC_STAGES];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int unsigned i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= m_tri_i;
         for (int unsigned i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

`ifdef GPIO_WT_DEBOUNCE_EN
   localparam int unsigned DW = $clog2(C_DEBOUNCE_CYCLES + 1);
   logic [DW-1:0] deb_cnt [W];
   logic [W-1:0]  din_q;

   // Output bit follows only after C_DEBOUNCE_CYCLES consecutive mismatching cycles.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         din_q <= '0;
         for (int unsigned b = 0; b < W; b++) deb_cnt[b] <= '0;
      end else begin
         for (int unsigned b = 0; b < W; b++) begin
            if (sync_q[C_SYNC_STAGES-1][b] != din_q[b]) begin
               if (deb_cnt[b] == DW'(C_DEBOUNCE_CYCLES - 1)) begin
                  din_q[b]   <= sync_q[C_SYNC_STAGES-1][b];
                  deb_cnt[b] <= '0;
               end else begin
                  deb_cnt[b] <= deb_cnt[b] + 1'b1;
               end
            end else begin
               deb_cnt[b] <= '0;
            end
         end
      end
   end

   assign s_tri_i = din_q;
`else
   assign s_tri_i = sync_q[C_SYNC_STAGES-1];
`endif

   // ---------------- edge detect ----------------
   logic [W-1:0]      prev_q;
   logic [W-1:0]      rise;
   logic [W-1:0]      fall;
   logic [W-1:0]      evt;
   logic [WARM_W-1:0] warm_q;
   logic              warm_done;

   assign warm_done = (warm_q == WARM_W'(WARM_MAX));

   always_comb begin
      rise = s_tri_i & ~prev_q;
      fall = ~s_tri_i & prev_q;
      case (C_EDGE_MODE)
         0:       evt = rise;
         1:       evt = fall;
         default: evt = rise | fall;
      endcase
      if (!warm_done) evt = '0;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         prev_q      <= '0;
         warm_q      <= '0;
         edge_status <= '0;
         irq         <= '0;
      end else begin
         prev_q <= s_tri_i;
         if (!warm_done) warm_q <= warm_q + 1'b1;
         // Set term is OR-ed last so a same-cycle clear never loses an event.
         edge_status <= (edge_status & ~edge_clr) | (evt & edge_mask);
         for (int unsigned c = 0; c < C_NUM_CH; c++)
            irq[c] <= |edge_status[c*C_TRI_WIDTH +: C_TRI_WIDTH];
      end
   end

endmodule

// File: tb/tb_gpio_wirethrough_sync.sv
// Directed bench for gpio_wirethrough_sync: three instances (rising/registered,
// falling/combinational, both-edges) sharing one stimulus stream.
module tb_gpio_wirethrough_sync;

   localparam int unsigned W = 32;
`ifdef GPIO_WT_DEBOUNCE_EN
   localparam int L = 18;
`else
   localparam int L = 2;
`endif

   logic         aclk = 1'b0;
   logic         areset;
   logic [W-1:0] s_tri_t, s_tri_o, m_tri_i, edge_mask, edge_clr;

   logic [W-1:0] s_tri_i0, m_tri_t0, m_tri_o0, st0;
   logic [W-1:0] s_tri_i1, m_tri_t1, m_tri_o1, st1;
   logic [W-1:0] s_tri_i2, m_tri_t2, m_tri_o2, st2;
   logic [0:0]   irq0, irq1, irq2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 aclk = ~aclk;

   gpio_wirethrough_sync #(.C_OUT_REG(1), .C_EDGE_MODE(0)) u0 (
      .aclk(aclk), .areset(areset), .s_tri_t(s_tri_t), .s_tri_o(s_tri_o),
      .s_tri_i(s_tri_i0), .m_tri_t(m_tri_t0), .m_tri_o(m_tri_o0), .m_tri_i(m_tri_i),
      .edge_mask(edge_mask), .edge_clr(edge_clr), .edge_status(st0), .irq(irq0));

   gpio_wirethrough_sync #(.C_OUT_REG(0), .C_EDGE_MODE(1)) u1 (
      .aclk(aclk), .areset(areset), .s_tri_t(s_tri_t), .s_tri_o(s_tri_o),
      .s_tri_i(s_tri_i1), .m_tri_t(m_tri_t1), .m_tri_o(m_tri_o1), .m_tri_i(m_tri_i),
      .edge_mask(edge_mask), .edge_clr(edge_clr), .edge_status(st1), .irq(irq1));

   gpio_wirethrough_sync #(.C_OUT_REG(1), .C_EDGE_MODE(2)) u2 (
      .aclk(aclk), .areset(areset), .s_tri_t(s_tri_t), .s_tri_o(s_tri_o),
      .s_tri_i(s_tri_i2), .m_tri_t(m_tri_t2), .m_tri_o(m_tri_o2), .m_tri_i(m_tri_i),
      .edge_mask(edge_mask), .edge_clr(edge_clr), .edge_status(st2), .irq(irq2));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1; m_tri_i = '1; s_tri_t = '1; s_tri_o = '0;
      edge_mask = '1; edge_clr = '0;
      tick(3);
      chk("rst_m_tri_t", m_tri_t0, '1);
      chk("rst_m_tri_o", m_tri_o0, '0);
      chk("rst_s_tri_i", s_tri_i0, '0);
      chk("rst_status", st0, '0);
      chk("rst_irq", W'(irq0), '0);

      // release with pins high: data arrives after L cycles, never flags an edge
      areset = 1'b0;
      tick(L - 1);
      chk("rel_s_tri_i_early", s_tri_i0, '0);
      tick(1);
      chk("rel_s_tri_i", s_tri_i0, '1);
      tick(L + 3);
      chk("rel_status_u0", st0, '0);
      chk("rel_status_u1", st1, '0);
      chk("rel_status_u2", st2, '0);
      chk("rel_irq_u2", W'(irq2), '0);

      // output path
      s_tri_t = '0; s_tri_o = 32'hA5A5A5A5;
      #1;
      chk("comb_m_tri_o", m_tri_o1, 32'hA5A5A5A5);
      chk("comb_m_tri_t", m_tri_t1, '0);
      chk("reg_m_tri_o_before", m_tri_o0, '0);
      tick(1);
      chk("reg_m_tri_o", m_tri_o0, 32'hA5A5A5A5);
      chk("reg_m_tri_t", m_tri_t0, '0);

      // rising edge on bit 0 -> status, irq, clear
      edge_mask = 32'h1; m_tri_i = '0;
      tick(L + 3);
      edge_clr = '1; tick(1); edge_clr = '0; tick(2);
      chk("pre_status_u1", st1, '0);
      chk("pre_irq_u1", W'(irq1), '0);
      m_tri_i = 32'h1;
      tick(L);
      chk("rise_status_early", st0, '0);
      tick(1);
      chk("rise_status", st0, 32'h1);
      chk("rise_irq_early", W'(irq0), '0);
      chk("rise_status_fallmode", st1, '0);
      chk("rise_status_both", st2, 32'h1);
      tick(1);
      chk("rise_irq", W'(irq0), 32'h1);
      edge_clr = 32'h1;
      tick(1);
      chk("clr_status", st0, '0);
      chk("clr_irq_lag", W'(irq0), 32'h1);
      edge_clr = '0;
      tick(1);
      chk("clr_irq", W'(irq0), '0);

      // set wins over simultaneous clear
      m_tri_i = '0;
      tick(L + 3);
      chk("fall_status_both", st2, 32'h1);
      chk("fall_status_rise", st0, '0);
      m_tri_i = 32'h1;
      tick(L);
      edge_clr = 32'h1;
      tick(1);
      chk("setclr_u0", st0, 32'h1);
      chk("setclr_u2", st2, 32'h1);
      edge_clr = '0;
      tick(1);
      chk("setclr_irq", W'(irq0), 32'h1);

      // edge modes on bit 3
      edge_clr = '1; tick(1); edge_clr = '0;
      edge_mask = 32'h8; m_tri_i = 32'h9;
      tick(L + 3);
      chk("b3_rise_u0", st0, 32'h8);
      chk("b3_rise_u1", st1, '0);
      chk("b3_rise_u2", st2, 32'h8);
      edge_clr = '1; tick(1); edge_clr = '0;
      m_tri_i = 32'h1;
      tick(L + 3);
      chk("b3_fall_u0", st0, '0);
      chk("b3_fall_u1", st1, 32'h8);
      chk("b3_fall_u2", st2, 32'h8);
      chk("b3_fall_irq_u1", W'(irq1), 32'h1);

      // mask changes neither clear nor retro-set
      edge_mask = '0;
      tick(2);
      chk("mask_keep", st1, 32'h8);
      edge_mask = '1;
      tick(2);
      chk("unmask_noretro", st0, '0);

      // asynchronous reset mid-operation, then warm-up restart with pin bit0 high
      areset = 1'b1;
      #1;
      chk("arst_status", st1, '0);
      chk("arst_irq", W'(irq1), '0);
      chk("arst_m_tri_t", m_tri_t0, '1);
      chk("arst_s_tri_i", s_tri_i0, '0);
      tick(1);
      areset = 1'b0;
      tick(L + 4);
      chk("warm_s_tri_i", s_tri_i0, 32'h1);
      chk("warm_status", st0, '0);

`ifdef GPIO_WT_DEBOUNCE_EN
      m_tri_i = '0;
      tick(L + 3);
      edge_mask = 32'h1; edge_clr = '1; tick(1); edge_clr = '0;
      m_tri_i = 32'h1;
      tick(10);
      m_tri_i = '0;
      for (int i = 0; i < 25; i++) begin
         tick(1);
         chk("deb_glitch", s_tri_i0, '0);
      end
      chk("deb_glitch_status", st0, '0);
      m_tri_i = 32'h1;
      tick(L - 1);
      chk("deb_early", s_tri_i0, '0);
      tick(1);
      chk("deb_pass", s_tri_i0, 32'h1);
      tick(1);
      chk("deb_status", st0, 32'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
